// File: rtl/md_unit_if.sv
// Handshake/result bundle between the execute-stage controller and the multiply/divide unit.
// WIDTH must match the unit's WIDTH parameter.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output Start, Op, A, B, input Busy, HI, LO);
  modport slave  (input Start, Op, A, B, output Busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed at the start
// edge, parked in pHI/pLO, and committed when the busy down-counter expires.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);
  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] phi_q, phi_d, plo_q, plo_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             skip_q, skip_d;

  logic               is_signed, a_neg, b_neg;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic [WIDTH-1:0]   a_mag, b_mag, b_div, quo_mag, rem_mag, quo, rem;

  // Divide on magnitudes so that -2^(WIDTH-1) / -1 wraps to itself instead of overflowing.
  always_comb begin
    is_signed = ~bus.Op[0];
    a_neg     = is_signed & bus.A[WIDTH-1];
    b_neg     = is_signed & bus.B[WIDTH-1];
    a_ext     = {{WIDTH{a_neg}}, bus.A};
    b_ext     = {{WIDTH{b_neg}}, bus.B};
    prod      = a_ext * b_ext;
    a_mag     = a_neg ? -bus.A : bus.A;
    b_mag     = b_neg ? -bus.B : bus.B;
    b_div     = (bus.B == '0) ? WIDTH'(1) : b_mag;
    quo_mag   = a_mag / b_div;
    rem_mag   = a_mag % b_div;
    quo       = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
    rem       = a_neg ? -rem_mag : rem_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phi_d   = phi_q;
    plo_d   = plo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    skip_d  = skip_q;
    case (state_q)
      StIdle: begin
        if (bus.Start) begin
          case (bus.Op)
            3'd0, 3'd1: begin
              phi_d   = prod[2*WIDTH-1:WIDTH];
              plo_d   = prod[WIDTH-1:0];
              skip_d  = 1'b0;
              cnt_d   = CntW'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = StRun;
            end
            3'd2, 3'd3: begin
              phi_d   = rem;
              plo_d   = quo;
              skip_d  = (bus.B == '0);
              cnt_d   = CntW'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = StRun;
            end
            3'd4:    hi_d = bus.A;
            3'd5:    lo_d = bus.A;
            default: ;
          endcase
        end
      end
      StRun: begin
        // Start is deliberately ignored here, even on the commit edge.
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          busy_d  = 1'b0;
          state_d = StIdle;
          if (!skip_q) begin
            hi_d = phi_q;
            lo_d = plo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      skip_q  <= skip_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: a default 32-bit unit and a 16-bit unit with MULT_CYCLES=1, checked every
// cycle against an arithmetic model plus literal expectations.
module tb_md_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if #(.WIDTH(32)) if0 ();
  md_unit_if #(.WIDTH(16)) if1 ();

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Model state per unit: architectural HI/LO/Busy plus the pending result and cycles left.
  logic [31:0] m_hi [2];
  logic [31:0] m_lo [2];
  logic [31:0] m_phi [2];
  logic [31:0] m_plo [2];
  bit          m_busy [2];
  bit          m_skip [2];
  int          m_left [2];
  int          w_of  [2] = '{32, 16};
  int          mc_of [2] = '{5, 1};
  int          dc_of [2] = '{10, 3};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_op(input int w, input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [31:0] hi,
                                   output logic [31:0] lo, output bit skip);
    longint mask, ua, ub, sa, sb, num, den, q, r;
    logic [63:0] p;
    mask = (longint'(1) << w) - 1;
    ua   = longint'({32'b0, a}) & mask;
    ub   = longint'({32'b0, b}) & mask;
    sa   = ua[w-1] ? ua - (longint'(1) << w) : ua;
    sb   = ub[w-1] ? ub - (longint'(1) << w) : ub;
    skip = 1'b0;
    hi   = '0;
    lo   = '0;
    if (op < 3'd2) begin
      p  = (op == 3'd0) ? 64'(sa * sb) : 64'(ua * ub);
      hi = 32'((p >> w) & 64'(mask));
      lo = 32'(p & 64'(mask));
    end else begin
      num  = (op == 3'd2) ? sa : ua;
      den  = (op == 3'd2) ? sb : ub;
      skip = (den == 0);
      if (!skip) begin
        q  = num / den;
        r  = num % den;
        hi = 32'(r & mask);
        lo = 32'(q & mask);
      end
    end
  endfunction

  task automatic model_step(input int u, input bit rst, input bit st, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
    if (rst) begin
      m_hi[u] = '0; m_lo[u] = '0; m_phi[u] = '0; m_plo[u] = '0;
      m_busy[u] = 1'b0; m_skip[u] = 1'b0; m_left[u] = 0;
    end else if (m_busy[u]) begin
      m_left[u]--;
      if (m_left[u] == 0) begin
        m_busy[u] = 1'b0;
        if (!m_skip[u]) begin
          m_hi[u] = m_phi[u];
          m_lo[u] = m_plo[u];
        end
      end
    end else if (st) begin
      if (op <= 3'd3) begin
        model_op(w_of[u], op, a, b, m_phi[u], m_plo[u], m_skip[u]);
        m_busy[u] = 1'b1;
        m_left[u] = (op < 3'd2) ? mc_of[u] : dc_of[u];
      end else if (op == 3'd4) begin
        m_hi[u] = a;
      end else if (op == 3'd5) begin
        m_lo[u] = a;
      end
    end
  endtask

  // One clock: drive unit u (the other unit sees Start=0), advance model, settle past the edge.
  task automatic cyc(input int u, input bit rst, input bit st, input logic [2:0] op,
                     input logic [31:0] a, input logic [31:0] b);
    reset     = rst;
    if0.Start = (u == 0) && st;
    if0.Op    = op;
    if0.A     = a;
    if0.B     = b;
    if1.Start = (u == 1) && st;
    if1.Op    = op;
    if1.A     = a[15:0];
    if1.B     = b[15:0];
    @(posedge clk);
    model_step(0, rst, (u == 0) && st, op, a, b);
    model_step(1, rst, (u == 1) && st, op, {16'b0, a[15:0]}, {16'b0, b[15:0]});
    #1;
  endtask

  function automatic logic busy_of(input int u);
    return (u == 0) ? if0.Busy : if1.Busy;
  endfunction
  function automatic logic [31:0] hi_of(input int u);
    return (u == 0) ? if0.HI : {16'b0, if1.HI};
  endfunction
  function automatic logic [31:0] lo_of(input int u);
    return (u == 0) ? if0.LO : {16'b0, if1.LO};
  endfunction

  task automatic run_op(input int u, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int n);
    cyc(u, 1'b0, 1'b1, op, a, b);
    n = 0;
    while (busy_of(u) === 1'b1 && n < 100) begin
      n++;
      cyc(u, 1'b0, 1'b0, 3'd0, '0, '0);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_busy0", 32'(if0.Busy), 32'(m_busy[0]));
      check("model_hi0", if0.HI, m_hi[0]);
      check("model_lo0", if0.LO, m_lo[0]);
      check("model_busy1", 32'(if1.Busy), 32'(m_busy[1]));
      check("model_hi1", {16'b0, if1.HI}, m_hi[1]);
      check("model_lo1", {16'b0, if1.LO}, m_lo[1]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    cyc(0, 1'b1, 1'b0, 3'd0, '0, '0);
    cyc(0, 1'b1, 1'b0, 3'd0, '0, '0);
    chk_en = 1'b1;
    cyc(0, 1'b0, 1'b0, 3'd0, '0, '0);
    check("reset_busy", 32'(busy_of(0)), 32'd0);
    check("reset_hi", hi_of(0), 32'd0);
    check("reset_lo", lo_of(0), 32'd0);
    cyc(0, 1'b0, 1'b1, 3'd6, 32'd123, 32'd45);
    check("nop_busy", 32'(busy_of(0)), 32'd0);
    check("nop_hi", hi_of(0), 32'd0);

    run_op(0, 3'd0, 32'hFFFF_FFFE, 32'd3, n);
    check("mult_cycles", n, 32'd5);
    check("mult_hi", hi_of(0), 32'hFFFF_FFFF);
    check("mult_lo", lo_of(0), 32'hFFFF_FFFA);
    run_op(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("multu_hi", hi_of(0), 32'hFFFF_FFFE);
    check("multu_lo", lo_of(0), 32'h0000_0001);
    run_op(0, 3'd2, 32'hFFFF_FFF9, 32'd2, n);
    check("div_cycles", n, 32'd10);
    check("div_lo", lo_of(0), 32'hFFFF_FFFD);
    check("div_hi", hi_of(0), 32'hFFFF_FFFF);
    run_op(0, 3'd3, 32'd7, 32'd2, n);
    check("divu_lo", lo_of(0), 32'd3);
    check("divu_hi", hi_of(0), 32'd1);
    run_op(0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("divovf_lo", lo_of(0), 32'h8000_0000);
    check("divovf_hi", hi_of(0), 32'd0);

    cyc(0, 1'b0, 1'b1, 3'd4, 32'h11, '0);
    cyc(0, 1'b0, 1'b1, 3'd5, 32'h22, '0);
    check("mthi", hi_of(0), 32'h11);
    check("mtlo", lo_of(0), 32'h22);
    run_op(0, 3'd3, 32'd5, 32'd0, n);
    check("div0_cycles", n, 32'd10);
    check("div0_hi", hi_of(0), 32'h11);
    check("div0_lo", lo_of(0), 32'h22);

    // Starts while busy: MTLO mid-run and MULT on the commit edge are dropped.
    cyc(0, 1'b0, 1'b1, 3'd0, 32'd2, 32'd3);
    cyc(0, 1'b0, 1'b0, 3'd0, '0, '0);
    cyc(0, 1'b0, 1'b0, 3'd0, '0, '0);
    cyc(0, 1'b0, 1'b1, 3'd5, 32'h55, '0);
    cyc(0, 1'b0, 1'b0, 3'd0, '0, '0);
    cyc(0, 1'b0, 1'b1, 3'd0, 32'd100, 32'd100);
    check("busystart_busy", 32'(busy_of(0)), 32'd0);
    check("busystart_lo", lo_of(0), 32'd6);
    check("busystart_hi", hi_of(0), 32'd0);
    run_op(0, 3'd1, 32'd4, 32'd5, n);
    check("backtoback_cycles", n, 32'd5);
    check("backtoback_lo", lo_of(0), 32'd20);

    cyc(0, 1'b0, 1'b1, 3'd2, 32'd100, 32'd7);
    cyc(0, 1'b0, 1'b0, 3'd0, '0, '0);
    cyc(0, 1'b1, 1'b0, 3'd0, '0, '0);
    check("abort_busy", 32'(busy_of(0)), 32'd0);
    check("abort_lo", lo_of(0), 32'd0);
    for (int i = 0; i < 15; i++) cyc(0, 1'b0, 1'b0, 3'd0, '0, '0);
    check("abort_nocommit_hi", hi_of(0), 32'd0);
    check("abort_nocommit_lo", lo_of(0), 32'd0);

    cyc(0, 1'b0, 1'b1, 3'd4, 32'h33, '0);
    check("mthi2", hi_of(0), 32'h33);
    cyc(0, 1'b1, 1'b1, 3'd4, 32'h44, '0);
    check("reset_wins", hi_of(0), 32'd0);

    run_op(1, 3'd0, 32'h0000_FFFE, 32'd3, n);
    check("w16_mult_cycles", n, 32'd1);
    check("w16_mult_hi", hi_of(1), 32'h0000_FFFF);
    check("w16_mult_lo", lo_of(1), 32'h0000_FFFA);
    run_op(1, 3'd1, 32'h0000_FFFF, 32'h0000_FFFF, n);
    check("w16_multu_hi", hi_of(1), 32'h0000_FFFE);
    check("w16_multu_lo", lo_of(1), 32'h0000_0001);
    run_op(1, 3'd2, 32'h0000_8000, 32'h0000_FFFF, n);
    check("w16_div_cycles", n, 32'd3);
    check("w16_div_lo", lo_of(1), 32'h0000_8000);
    check("w16_div_hi", hi_of(1), 32'd0);

    cyc(0, 1'b0, 1'b0, 3'd0, '0, '0);
    cyc(0, 1'b0, 1'b0, 3'd0, '0, '0);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers, sitting in the execute stage of the pipelined `cpu` beside the ALU. It accepts one operation per start pulse, holds `Busy` for a configurable number of cycles, then commits the result to HI/LO. `Busy` feeds the controller's stall logic so later HI/LO readers and mult/div starts stall while an operation is in flight.

## Interface
- `WIDTH`, 32: operand and HI/LO width, any value ≥ 2.
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU, ≥ 1.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU, ≥ 1.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `Start`  in  1  sample `Op`/`A`/`B` this edge.
- `Op`  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op.
- `A`  in  WIDTH  rs operand: multiplicand or dividend; MTHI/MTLO data.
- `B`  in  WIDTH  rt operand: multiplier or divisor.
- `Busy`  out  1  operation in flight.
- `HI`  out  WIDTH  HI register.
- `LO`  out  WIDTH  LO register.

## Operation
- States: IDLE and RUN.
- Down-counter `cnt` has width clog2(max(MULT_CYCLES, DIV_CYCLES)) + 1.
- Pending result registers `pHI` and `pLO` hold the computed result until commit.
- IDLE, `Start=1`, `Op` in 0–3:
  - compute the result from A/B at this edge and latch it into `pHI`/`pLO`;
  - load `cnt` with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- IDLE, `Start=1`, `Op`=4/5: HI (resp. LO) ← A at this edge; stay IDLE; `Busy` stays 0.
- IDLE, `Start=1`, `Op`=6/7: no effect.
- RUN: decrement `cnt` each edge. The edge on which `cnt` reaches 0 does three things:
  - HI ← `pHI`, LO ← `pLO`;
  - return to IDLE;
  - clear `Busy`.
- `Start` while in RUN is ignored for every `Op`, including the final RUN cycle. The controller guarantees this never happens, but the block must not corrupt state if it does.
- MULT: {HI,LO} = signed A × signed B, full 2·WIDTH product.
- MULTU: {HI,LO} = unsigned product.
- DIV:
  - LO = quotient truncated toward zero; HI = remainder with the sign of A.
  - A = −2^(WIDTH−1), B = −1: LO = 0x80000000, HI = 0 (WIDTH=32).
- DIVU: unsigned quotient to LO, unsigned remainder to HI.
- B = 0 (DIV/DIVU): the full busy period still runs, then HI/LO are left unchanged. `pHI`/`pLO` are don't-care.
- The result may be computed combinationally at start, or iteratively over the busy cycles. Only commit timing and values are specified.

## Timing
- Reset values: `Busy`=0, `HI`=0, `LO`=0, state IDLE, `cnt`=0, `pHI`/`pLO`=0.
- `reset` during RUN aborts the operation: no commit, and every output takes its reset value at that edge.
- `reset` and `Start` in the same cycle: reset wins.
- `Busy` is a registered output:
  - rises at the start edge t0;
  - stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES);
  - falls at edge t0+N, the same edge HI/LO take the new value.
- A new `Start` is accepted at edge t0+N+1 at the earliest, i.e. the first edge with `Busy`=0 beforehand.
- MTHI/MTLO latency is 1: the value appears on HI/LO after the edge.
- HI/LO outputs are register values with no combinational path from inputs.

## Test plan
- Reset/idle:
  - Stimulus: reset for 2 cycles, then idle.
  - Expected: `Busy`=0, HI=LO=0; `Start` with Op=6 leaves all outputs unchanged.
- MULT:
  - Stimulus: A=0xFFFFFFFE (−2), B=3, default parameters.
  - Expected: `Busy` high exactly 5 cycles; HI=0xFFFFFFFF and LO=0xFFFFFFFA appear on the same edge `Busy` falls; HI/LO unchanged during busy.
- MULTU / DIV / DIVU:
  - MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
  - DIV A=−7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF after 10 busy cycles.
  - DIVU A=7, B=2 → LO=3, HI=1.
- Corner divides:
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU by 0 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO → 10 busy cycles, then HI=0x11, LO=0x22.
- Busy-time starts:
  - MTLO A=0x55 issued during a MULT's third busy cycle is ignored.
  - A second MULT `Start` on the final busy cycle is ignored.
  - A `Start` on the cycle after `Busy` falls is accepted.
- Reset mid-operation and parameters:
  - Reset on the second cycle of a DIV → `Busy`=0, HI=LO=0 next cycle, and no later commit.
  - Repeat the MULT test with MULT_CYCLES=1 and WIDTH=16 → one busy cycle, correct 16-bit HI/LO.
